// File: rtl/fc_pkg.sv
// fc_pkg: shared types and requantization helper for the fully-connected layer datapath
package fc_pkg;
  typedef enum logic {COLLECT, DRAIN} collector_state_t;
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value, input int shift, input int to);
    logic signed [63:0] s, hi, lo;
    s  = value >>> shift;
    hi = (64'sd1 <<< (to - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (to - 1));
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/fc_requant_sat.sv
// fc_requant_sat: combinational arithmetic right shift followed by signed saturation to TO bits
module fc_requant_sat
  import fc_pkg::*;
#(
  parameter int T     = 16,
  parameter int TO    = 8,
  parameter int SHIFT = 4
) (
  input  logic [T-1:0]  value,
  output logic [TO-1:0] q
);
  assign q = TO'(sat_shift(64'($signed(value)), SHIFT, TO));
endmodule

// File: rtl/fc_output_collector.sv
// fc_output_collector: buffers a requantized M-word layer result, tracks its argmax,
// then replays it downstream with a last flag and the winning class index.
module fc_output_collector
  import fc_pkg::*;
#(
  parameter int M     = 4,
  parameter int T     = 16,
  parameter int TO    = 8,
  parameter int SHIFT = 4,
  localparam int IW   = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [T-1:0]  input_data,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [TO-1:0] output_data,
  output logic          output_last,
  output logic [IW-1:0] output_idx
);
  collector_state_t state, state_nx;
  logic [IW-1:0] wcnt, rcnt, idx_v, idx_nx, out_idx_q;
  logic [T-1:0]  max_v;
  logic [TO-1:0] vec_q [M];
  logic [TO-1:0] q, data_q;
  logic          acc, xfer, w_last, r_last, take;
  fc_requant_sat #(.T(T), .TO(TO), .SHIFT(SHIFT)) u_rq (.value(input_data), .q(q));
  always_comb begin
    acc      = input_valid && state == COLLECT;
    xfer     = output_ready && state == DRAIN;
    w_last   = wcnt == IW'(M - 1);
    r_last   = rcnt == IW'(M - 1);
    take     = wcnt == '0 || $signed(input_data) > $signed(max_v);
    idx_nx   = take ? wcnt : idx_v;
    state_nx = acc && w_last ? DRAIN : xfer && r_last ? COLLECT : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= COLLECT;
      wcnt      <= '0;
      rcnt      <= '0;
      max_v     <= '0;
      idx_v     <= '0;
      data_q    <= '0;
      out_idx_q <= '0;
      for (int i = 0; i < M; i++) vec_q[i] <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        vec_q[wcnt] <= q;
        wcnt        <= w_last ? '0 : wcnt + IW'(1);
        if (take) begin
          max_v <= input_data;
          idx_v <= wcnt;
        end
        // element 0 was written earlier (M >= 2), so it can be presented as DRAIN starts
        if (w_last) begin
          out_idx_q <= idx_nx;
          data_q    <= vec_q[0];
        end
      end
      if (xfer) begin
        rcnt <= r_last ? '0 : rcnt + IW'(1);
        if (!r_last) data_q <= vec_q[rcnt + IW'(1)];
      end
    end
  end
  assign input_ready  = state == COLLECT;
  assign output_valid = state == DRAIN;
  assign output_last  = state == DRAIN && r_last;
  assign output_data  = data_q;
  assign output_idx   = out_idx_q;
endmodule

// File: tb/tb_fc_output_collector.sv
// tb_fc_output_collector: randomized and directed checks of fc_output_collector against a behavioural model
module tb_fc_output_collector;
  localparam int M = 4, T = 16, TO = 8, SHIFT = 4;
  logic clk = 0, reset = 0, input_valid = 0, output_ready = 0;
  logic [T-1:0] input_data = '0;
  logic input_ready, output_valid, output_last;
  logic [TO-1:0] output_data;
  logic [1:0] output_idx;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fc_output_collector #(.M(M), .T(T), .TO(TO), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_last(output_last), .output_idx(output_idx));
  function automatic int ref_q(int v);
    int s;
    s = v >>> SHIFT;
    return s > 127 ? 127 : s < -128 ? -128 : s;
  endfunction
  function automatic int ref_idx(int v[4]);
    int b;
    b = 0;
    for (int i = 1; i < 4; i++) if (v[i] > v[b]) b = i;
    return b;
  endfunction
  function automatic int rnd_word();
    return ($urandom_range(3) == 0) ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(10000)) - 5000;
  endfunction
  task automatic push_vec(input int v[4]);
    for (int i = 0; i < 4; i++) begin
      input_valid = 1;
      input_data  = T'(v[i]);
      @(posedge clk); #1;
    end
    input_valid = 0;
  endtask
  task automatic test_reset;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (output_valid !== 0 || output_last !== 0 || output_data !== 0 || output_idx !== 0)
      begin n_bad++; $display("FAIL reset: valid=%b last=%b data=%0d idx=%0d, need all 0", output_valid, output_last, output_data, output_idx); end
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (input_ready !== 1 || output_valid !== 0)
      begin n_bad++; $display("FAIL reset_release: ready=%b valid=%b, need ready=1 valid=0", input_ready, output_valid); end
  endtask
  task automatic test_directed;
    int dv[4][4], de[4][4], di[4];
    dv[0] = '{160, -32, 48, 16};      de[0] = '{10, -2, 3, 1};        di[0] = 0;
    dv[1] = '{4000, -4000, -1, 2047}; de[1] = '{127, -128, -1, 127};  di[1] = 0;
    dv[2] = '{16, 300, 300, -5};      de[2] = '{1, 18, 18, -1};       di[2] = 1;
    dv[3] = '{-7, -7, -7, -7};        de[3] = '{-1, -1, -1, -1};      di[3] = 0;
    for (int c = 0; c < 4; c++) begin
      push_vec(dv[c]);
      n_cmp++;
      if (output_valid !== 1 || input_ready !== 0)
        begin n_bad++; $display("FAIL directed[%0d] latency: valid=%b ready=%b, need valid=1 ready=0", c, output_valid, input_ready); end
      output_ready = 1;
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (output_data !== TO'(de[c][i]) || output_last !== (i == 3) || output_idx !== 2'(di[c]))
          begin n_bad++; $display("FAIL directed[%0d] word %0d: got data=%0d last=%b idx=%0d, need data=%0d last=%b idx=%0d",
            c, i, $signed(output_data), output_last, output_idx, de[c][i], (i == 3), di[c]); end
        @(posedge clk); #1;
      end
      output_ready = 0;
      n_cmp++;
      if (output_valid !== 0 || input_ready !== 1 || output_last !== 0)
        begin n_bad++; $display("FAIL directed[%0d] end: valid=%b ready=%b last=%b, need 0 1 0", c, output_valid, input_ready, output_last); end
    end
  endtask
  task automatic test_random;
    int v[4];
    int got, cyc;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) v[i] = rnd_word();
      push_vec(v);
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 100) begin
        output_ready = 1'($urandom_range(1));
        n_cmp++;
        if (output_valid !== 1 || input_ready !== 0 || output_data !== TO'(ref_q(v[got])) ||
            output_last !== (got == 3) || output_idx !== 2'(ref_idx(v)))
          begin n_bad++; $display("FAIL random[%0d] word %0d: got valid=%b ready=%b data=%0d last=%b idx=%0d, need 1 0 %0d %b %0d",
            n, got, output_valid, input_ready, $signed(output_data), output_last, output_idx, ref_q(v[got]), (got == 3), ref_idx(v)); end
        if (output_ready) got++;
        @(posedge clk); #1;
        cyc++;
      end
      output_ready = 0;
      n_cmp++;
      if (got != 4 || output_valid !== 0)
        begin n_bad++; $display("FAIL random[%0d] drain: got %0d words valid=%b, need 4 words valid=0", n, got, output_valid); end
    end
  endtask
  task automatic test_backpressure;
    int v[4];
    for (int i = 0; i < 4; i++) v[i] = rnd_word();
    push_vec(v);
    output_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        output_ready = 0;
        for (int s = 0; s < 3; s++) begin
          input_valid = 1;
          input_data  = T'($urandom);
          n_cmp++;
          if (output_valid !== 1 || input_ready !== 0 || output_data !== TO'(ref_q(v[2])) || output_last !== 0 || output_idx !== 2'(ref_idx(v)))
            begin n_bad++; $display("FAIL backpressure stall %0d: got valid=%b ready=%b data=%0d last=%b idx=%0d, need 1 0 %0d 0 %0d",
              s, output_valid, input_ready, $signed(output_data), output_last, output_idx, ref_q(v[2]), ref_idx(v)); end
          @(posedge clk); #1;
        end
        input_valid  = 0;
        output_ready = 1;
      end
      n_cmp++;
      if (output_valid !== 1 || output_data !== TO'(ref_q(v[i])) || output_last !== (i == 3) || output_idx !== 2'(ref_idx(v)))
        begin n_bad++; $display("FAIL backpressure word %0d: got valid=%b data=%0d last=%b idx=%0d, need 1 %0d %b %0d",
          i, output_valid, $signed(output_data), output_last, output_idx, ref_q(v[i]), (i == 3), ref_idx(v)); end
      @(posedge clk); #1;
    end
    output_ready = 0;
    n_cmp++;
    if (output_valid !== 0 || input_ready !== 1)
      begin n_bad++; $display("FAIL backpressure end: valid=%b ready=%b, need 0 1", output_valid, input_ready); end
  endtask
  task automatic test_reset_mid;
    int v[4], f[4], e[4];
    v = '{1000, 2000, -300, 500};
    f = '{32, 64, 96, 128};
    e = '{2, 4, 6, 8};
    push_vec(v);
    output_ready = 1;
    @(posedge clk); #1;
    output_ready = 0;
    reset = 0;
    #1;
    n_cmp++;
    if (output_valid !== 0 || output_last !== 0 || output_data !== 0 || output_idx !== 0 || input_ready !== 1)
      begin n_bad++; $display("FAIL reset_mid: valid=%b last=%b data=%0d idx=%0d ready=%b, need 0 0 0 0 1",
        output_valid, output_last, output_data, output_idx, input_ready); end
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    push_vec(f);
    output_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (output_valid !== 1 || output_data !== TO'(e[i]) || output_last !== (i == 3) || output_idx !== 2'd3)
        begin n_bad++; $display("FAIL reset_mid fresh word %0d: got valid=%b data=%0d last=%b idx=%0d, need 1 %0d %b 3",
          i, output_valid, $signed(output_data), output_last, output_idx, e[i], (i == 3)); end
      @(posedge clk); #1;
    end
    output_ready = 0;
  endtask
  task automatic test_back_to_back;
    int a[4], b[4], w[8];
    int k, got, acc4, last0, ia, ib;
    for (int i = 0; i < 4; i++) begin a[i] = rnd_word(); b[i] = rnd_word(); w[i] = a[i]; w[i+4] = b[i]; end
    ia = ref_idx(a);
    ib = ref_idx(b);
    k = 0; got = 0; acc4 = -1; last0 = -1;
    output_ready = 1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      input_valid = k < 8;
      input_data  = T'(w[k < 8 ? k : 7]);
      if (output_valid) begin
        n_cmp++;
        if (output_data !== TO'(ref_q(w[got])) || output_last !== (got % 4 == 3) || output_idx !== 2'(got < 4 ? ia : ib))
          begin n_bad++; $display("FAIL back_to_back word %0d: got data=%0d last=%b idx=%0d, need %0d %b %0d",
            got, $signed(output_data), output_last, output_idx, ref_q(w[got]), (got % 4 == 3), got < 4 ? ia : ib); end
        if (got == 3) last0 = cyc;
        got++;
      end
      if (input_ready && k < 8) begin
        if (k == 4) acc4 = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    input_valid  = 0;
    output_ready = 0;
    n_cmp++;
    if (got != 8 || k != 8 || acc4 != last0 + 1)
      begin n_bad++; $display("FAIL back_to_back flow: got=%0d sent=%0d accept4=%0d lastxfer=%0d, need 8 8 and accept4=lastxfer+1",
        got, k, acc4, last0); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
